// File: rtl/sample_frame_packer.sv
// Sample frame packer: gathers four addressed samples into one frame and
// hands it to a consumer through a valid/ready output register.
module sample_frame_packer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SLOTS  = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [2:0]          add_i,
  input  logic                we_i,
  input  logic [DATA_W-1:0]   data_i,
  input  logic                clr_i,
  output logic [4*DATA_W-1:0] frame_o,
  output logic                frame_valid_o,
  input  logic                frame_ready_i,
  output logic [3:0]          fill_o,
  output logic                overflow_o,
  output logic                addr_err_o
);

  localparam int unsigned FRAME_W = 4 * DATA_W;

  typedef enum logic {
    EMPTY = 1'b0,
    VALID = 1'b1
  } state_t;

  state_t state_q;
  state_t state_next;

  logic [DATA_W-1:0]  slot_q [SLOTS];
  logic               addr_ok;
  logic               wr_ok;
  logic [1:0]         wr_sel;
  logic [3:0]         mask_wr;
  logic [3:0]         mask_merged;
  logic               complete;
  logic               load_frame;
  logic               overflow_set;
  logic [FRAME_W-1:0] frame_next;

  // Decode the incoming write; clear takes priority and suppresses it.
  always_comb begin
    addr_ok     = (add_i[2] == 1'b0);
    wr_sel      = add_i[1:0];
    wr_ok       = we_i && !clr_i && addr_ok;
    mask_wr     = wr_ok ? (4'b0001 << wr_sel) : 4'b0000;
    mask_merged = fill_o | mask_wr;
    complete    = wr_ok && (mask_merged == 4'b1111);
  end

  // Assemble the candidate frame, bypassing the completing write's data.
  always_comb begin
    frame_next = '0;
    for (int unsigned k = 0; k < SLOTS; k++) begin
      if (wr_ok && (wr_sel == 2'(k))) begin
        frame_next[k*DATA_W +: DATA_W] = data_i;
      end else begin
        frame_next[k*DATA_W +: DATA_W] = slot_q[k];
      end
    end
  end

  // Output FSM state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_next;
    end
  end

  // Next state, frame load and overflow decisions.
  always_comb begin
    state_next   = state_q;
    load_frame   = 1'b0;
    overflow_set = 1'b0;
    case (state_q)
      EMPTY: begin
        if (complete) begin
          load_frame = 1'b1;
          state_next = VALID;
        end
      end
      VALID: begin
        if (complete) begin
          if (frame_ready_i) begin
            load_frame = 1'b1;
          end else begin
            overflow_set = 1'b1;
          end
        end else if (frame_ready_i) begin
          state_next = EMPTY;
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase
  end

  // Registered valid flag mirrors the next FSM state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      frame_valid_o <= 1'b0;
    end else begin
      frame_valid_o <= (state_next == VALID);
    end
  end

  // Output frame register; only changes when a new frame is accepted.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      frame_o <= '0;
    end else if (load_frame) begin
      frame_o <= frame_next;
    end
  end

  // Slot buffer; overwrites of an already-filled slot are allowed.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned k = 0; k < SLOTS; k++) begin
        slot_q[k] <= '0;
      end
    end else if (wr_ok) begin
      slot_q[wr_sel] <= data_i;
    end
  end

  // Fill mask; emptied by clear or by the completing write.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fill_o <= 4'b0000;
    end else if (clr_i || complete) begin
      fill_o <= 4'b0000;
    end else begin
      fill_o <= mask_merged;
    end
  end

  // Sticky overflow: a completed frame found the output still occupied.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      overflow_o <= 1'b0;
    end else if (clr_i) begin
      overflow_o <= 1'b0;
    end else if (overflow_set) begin
      overflow_o <= 1'b1;
    end
  end

  // Sticky address error: a write targeted a slot beyond 3.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      addr_err_o <= 1'b0;
    end else if (clr_i) begin
      addr_err_o <= 1'b0;
    end else if (we_i && !addr_ok) begin
      addr_err_o <= 1'b1;
    end
  end

endmodule

// File: doc/sample_frame_packer.md
SAMPLE_FRAME_PACKER -- requirements
Module: sample_frame_packer

Interface
REQ-001 Parameter DATA_W, default 8, width of one captured sample.
REQ-002 Parameter SLOTS, default 4, number of samples per frame; fixed at 4 in this revision, and the slot index is add_i[1:0].
REQ-003 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 RST  input  1  asynchronous, active-high reset.
REQ-005 add_i  input  3  slot address driven by the upstream address generator.
REQ-006 we_i  input  1  write strobe; when 1, the sample on data_i belongs to slot add_i.
REQ-007 data_i  input  DATA_W  sample data.
REQ-008 clr_i  input  1  synchronous clear of the fill mask and the sticky flags.
REQ-009 frame_o  output  4*DATA_W  packed frame; slot k occupies bits [k*DATA_W +: DATA_W].
REQ-010 frame_valid_o  output  1  frame_o holds an undelivered frame.
REQ-011 frame_ready_i  input  1  consumer accepts frame_o when frame_valid_o=1.
REQ-012 fill_o  output  4  current fill mask, where bit k=1 means slot k has been written.
REQ-013 overflow_o  output  1  sticky; a completed frame was dropped.
REQ-014 addr_err_o  output  1  sticky; a write arrived with add_i greater than 3.

Function
REQ-015 The block SHALL contain a 4-entry DATA_W slot buffer, a 4-bit fill mask, and a 2-state output FSM: EMPTY (frame_valid_o=0) and VALID (frame_valid_o=1).
REQ-016 When we_i=1 and add_i<=3, the block SHALL write data_i into slot add_i[1:0] and set the matching mask bit at that edge.
REQ-017 A write to a slot whose mask bit is already set SHALL overwrite the data and leave the mask unchanged.
REQ-018 When we_i=1 and add_i>=4, the block SHALL discard the write, leave the mask unchanged, and set addr_err_o.
REQ-019 A frame SHALL be complete on the edge where the mask, including the current write, reaches 4'b1111; this is the completing edge.
REQ-020 On the completing edge, the mask SHALL be cleared to 0, so fill_o reads 0 in the following cycle.
REQ-021 On the completing edge, if the FSM is EMPTY, or is VALID with frame_ready_i=1, the block SHALL load frame_o from the four slots and the completing write's data_i, and the FSM SHALL be VALID; latency is 1 cycle from the completing write.
REQ-022 On the completing edge, if the FSM is VALID and frame_ready_i=0, the block SHALL discard the new frame, hold frame_o unchanged, and set overflow_o.
REQ-023 In VALID with frame_ready_i=1 and no completing edge, the FSM SHALL move to EMPTY; frame_o then holds its last value.
REQ-024 frame_o SHALL remain stable while frame_valid_o=1 and frame_ready_i=0.
REQ-025 clr_i=1 SHALL clear the mask, overflow_o and addr_err_o at that edge, and SHALL ignore any we_i in the same cycle.
REQ-026 clr_i SHALL NOT affect the FSM state or frame_o.
REQ-027 Sticky flags SHALL remain set until clr_i or RST.

Reset
REQ-028 While RST=1, regardless of CLK, the block SHALL force: frame_valid_o=0, FSM=EMPTY, frame_o=0, fill_o=0, overflow_o=0, addr_err_o=0, all slots=0.
REQ-029 A reset asserted mid-fill or in VALID SHALL discard the partial or pending frame with no output transfer.
REQ-030 The first edge after RST deasserts SHALL operate normally.

Verification
REQ-031 Writes in address order 1,2,3,0 with data 0x11,0x22,0x33,0x44 -> frame_o=0x33221144 and frame_valid_o=1 one cycle after the last write; fill_o=0.
REQ-032 Frame pending with frame_ready_i=0, second full frame written -> overflow_o=1 and frame_o still holds the first frame; then frame_ready_i=1 for one cycle -> frame_valid_o=0.
REQ-033 Frame pending, and frame_ready_i=1 on the same edge as the next completing write -> frame_valid_o stays 1 and frame_o holds the new frame with no gap.
REQ-034 Write with add_i=5 -> addr_err_o=1 and fill_o unchanged; a subsequent clr_i pulse -> addr_err_o=0 and fill_o=0.
REQ-035 Slot 2 written twice (0xAA then 0xBB), then slots 0, 1 and 3 written -> frame_o slot 2 field = 0xBB.
REQ-036 RST asserted asynchronously between clock edges after 3 writes -> all outputs 0 immediately; then 4 new writes -> frame built only from the post-reset data.
